// File: rtl/operand_mux_arbiter_if.sv
// Handshake bundle between two operand requesters, the shared mux arbiter and the
// downstream pipeline-stage consumer.
interface operand_mux_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Requesters and consumer side
    modport master (
        output req0, data0, req1, data1, out_ready,
        input  gnt0, gnt1, sel, out_valid, out_data
    );

    // Arbiter side
    modport slave (
        input  req0, data0, req1, data1, out_ready,
        output gnt0, gnt1, sel, out_valid, out_data
    );
endinterface

// File: rtl/operand_mux_arbiter.sv
// Round-robin arbiter for a shared 2-to-1 operand mux feeding a one-entry registered
// output slot, with saturating per-requester grant counters for debug visibility.
module operand_mux_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          INIT_PRI = 1'b0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_mux_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]      gnt_cnt0,
    output logic [CNT_W-1:0]      gnt_cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               sel_q, sel_d;
    logic               pri_q, pri_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;
    logic               can_load_c;
    logic               gnt0_c;
    logic               gnt1_c;

    // Grant decision: slot free or draining this cycle, ties go to the priority holder
    always_comb begin
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        can_load_c = (state_q == EMPTY) || bus.out_ready;
        if (!rst && can_load_c) begin
            if (bus.req0 && (!bus.req1 || !pri_q)) begin
                gnt0_c = 1'b1;
            end else if (bus.req1) begin
                gnt1_c = 1'b1;
            end
        end
    end

    // Next-state: capture on grant, otherwise hold or drain
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        sel_d      = sel_q;
        pri_d      = pri_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        if (gnt0_c) begin
            state_d    = FULL;
            out_data_d = bus.data0;
            sel_d      = 1'b0;
            pri_d      = 1'b1;
            if (cnt0_q != {CNT_W{1'b1}}) begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
        end else if (gnt1_c) begin
            state_d    = FULL;
            out_data_d = bus.data1;
            sel_d      = 1'b1;
            pri_d      = 1'b0;
            if (cnt1_q != {CNT_W{1'b1}}) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end
        end else if ((state_q == FULL) && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            sel_q      <= 1'b0;
            pri_q      <= INIT_PRI;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            sel_q      <= sel_d;
            pri_q      <= pri_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.sel       = sel_q;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = out_data_q;
    assign gnt_cnt0      = cnt0_q;
    assign gnt_cnt1      = cnt1_q;

endmodule

// File: tb/tb_operand_mux_arbiter.sv
// Directed-vector bench for operand_mux_arbiter: a sequential table on the default
// configuration plus a hand-written INIT_PRI/saturation sequence on a narrow-counter instance.
module tb_operand_mux_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    operand_mux_arbiter_if #(.WIDTH(4)) bus   ();
    operand_mux_arbiter_if #(.WIDTH(4)) bus_s ();
    logic [7:0] gnt_cnt0, gnt_cnt1;
    logic [1:0] s_cnt0, s_cnt1;

    operand_mux_arbiter #(.WIDTH(4), .INIT_PRI(1'b0), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
    );

    operand_mux_arbiter #(.WIDTH(4), .INIT_PRI(1'b1), .CNT_W(2)) dut_sat (
        .clk      (clk),
        .rst      (rst_s),
        .bus      (bus_s),
        .gnt_cnt0 (s_cnt0),
        .gnt_cnt1 (s_cnt1)
    );

    typedef struct {
        logic       rst;
        logic       req0;
        logic [3:0] d0;
        logic       req1;
        logic [3:0] d1;
        logic       rdy;
        logic       g0;
        logic       g1;
        logic       v;
        logic [3:0] data;
        logic       sel;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    localparam int unsigned NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic q0, input logic [3:0] a0,
                                input logic q1, input logic [3:0] a1, input logic rd,
                                input logic eg0, input logic eg1, input logic ev,
                                input logic [3:0] ed, input logic es,
                                input logic [7:0] ec0, input logic [7:0] ec1);
        vec_t t;
        t.rst = r;   t.req0 = q0; t.d0 = a0; t.req1 = q1; t.d1 = a1; t.rdy = rd;
        t.g0 = eg0;  t.g1 = eg1;  t.v = ev;  t.data = ed;  t.sel = es;
        t.c0 = ec0;  t.c1 = ec1;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        //            rst q0 d0   q1 d1   rdy g0 g1 v  data sel c0 c1
        // reset held two cycles with both requests up
        vecs[0]  = mk(1, 1, 4'h9, 1, 4'h8, 1, 0, 0, 0, 4'h0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 4'h9, 1, 4'h8, 1, 0, 0, 0, 4'h0, 0, 0, 0);
        // single request from requester 0
        vecs[2]  = mk(0, 1, 4'h9, 0, 4'h0, 1, 1, 0, 1, 4'h9, 0, 1, 0);
        // re-reset so contention starts from INIT_PRI
        vecs[3]  = mk(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h0, 0, 0, 0);
        // contention alternates 0,1,0,1 at full throughput
        vecs[4]  = mk(0, 1, 4'h9, 1, 4'h8, 1, 1, 0, 1, 4'h9, 0, 1, 0);
        vecs[5]  = mk(0, 1, 4'h9, 1, 4'h8, 1, 0, 1, 1, 4'h8, 1, 1, 1);
        vecs[6]  = mk(0, 1, 4'h9, 1, 4'h8, 1, 1, 0, 1, 4'h9, 0, 2, 1);
        vecs[7]  = mk(0, 1, 4'h9, 1, 4'h8, 1, 0, 1, 1, 4'h8, 1, 2, 2);
        // drain: valid drops, data/sel hold
        vecs[8]  = mk(0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h8, 1, 2, 2);
        // fill with 9 then backpressure three cycles against req1
        vecs[9]  = mk(0, 1, 4'h9, 0, 4'h0, 1, 1, 0, 1, 4'h9, 0, 3, 2);
        vecs[10] = mk(0, 0, 4'h0, 1, 4'h8, 0, 0, 0, 1, 4'h9, 0, 3, 2);
        vecs[11] = mk(0, 0, 4'h0, 1, 4'h8, 0, 0, 0, 1, 4'h9, 0, 3, 2);
        vecs[12] = mk(0, 0, 4'h0, 1, 4'h8, 0, 0, 0, 1, 4'h9, 0, 3, 2);
        vecs[13] = mk(0, 0, 4'h0, 1, 4'h8, 1, 0, 1, 1, 4'h8, 1, 3, 3);
        // drain, then out_ready on an empty slot changes nothing
        vecs[14] = mk(0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h8, 1, 3, 3);
        vecs[15] = mk(0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h8, 1, 3, 3);
        // reset mid-transfer with req1 pending; pri would be 1 without the reset
        vecs[16] = mk(0, 1, 4'h9, 0, 4'h0, 1, 1, 0, 1, 4'h9, 0, 4, 3);
        vecs[17] = mk(0, 0, 4'h0, 1, 4'h8, 0, 0, 0, 1, 4'h9, 0, 4, 3);
        vecs[18] = mk(1, 0, 4'h0, 1, 4'h8, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        vecs[19] = mk(0, 1, 4'h9, 1, 4'h8, 1, 1, 0, 1, 4'h9, 0, 1, 0);

        rst_s         = 1'b1;
        bus_s.req0    = 1'b0; bus_s.data0 = 4'h0;
        bus_s.req1    = 1'b0; bus_s.data1 = 4'h0;
        bus_s.out_ready = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            rst           = vecs[i].rst;
            bus.req0      = vecs[i].req0;
            bus.data0     = vecs[i].d0;
            bus.req1      = vecs[i].req1;
            bus.data1     = vecs[i].d1;
            bus.out_ready = vecs[i].rdy;
            #2;
            check("gnt0", i, 32'(bus.gnt0), 32'(vecs[i].g0));
            check("gnt1", i, 32'(bus.gnt1), 32'(vecs[i].g1));
            @(posedge clk);
            #1;
            check("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].v));
            check("out_data",  i, 32'(bus.out_data),  32'(vecs[i].data));
            check("sel",       i, 32'(bus.sel),       32'(vecs[i].sel));
            check("gnt_cnt0",  i, 32'(gnt_cnt0),      32'(vecs[i].c0));
            check("gnt_cnt1",  i, 32'(gnt_cnt1),      32'(vecs[i].c1));
        end

        rst           = 1'b0;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.out_ready = 1'b1;

        // narrow-counter instance: release reset, INIT_PRI=1 wins the first tie
        @(posedge clk);
        #1;
        rst_s       = 1'b0;
        bus_s.req0  = 1'b1; bus_s.data0 = 4'h5;
        bus_s.req1  = 1'b1; bus_s.data1 = 4'hA;
        #2;
        check("sat_init_gnt0", 0, 32'(bus_s.gnt0), 32'd0);
        check("sat_init_gnt1", 0, 32'(bus_s.gnt1), 32'd1);
        @(posedge clk);
        #1;
        check("sat_init_data", 0, 32'(bus_s.out_data), 32'hA);
        check("sat_init_sel",  0, 32'(bus_s.sel),      32'd1);

        // five back-to-back grants to requester 0; counter sticks at 3
        bus_s.req1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #2;
            check("sat_gnt0", k, 32'(bus_s.gnt0), 32'd1);
            @(posedge clk);
            #1;
            check("sat_cnt0", k, 32'(s_cnt0), (k >= 3) ? 32'd3 : 32'(k));
        end
        check("sat_cnt1", 6, 32'(s_cnt1), 32'd1);
        check("sat_valid", 6, 32'(bus_s.out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
